// File: rtl/ccdiv_seq.sv
// Sequential fixed-point complex divider q = a / b. The numerator is a * conj(b) and the
// denominator is |b|^2. Two restoring dividers produce the magnitudes, which are then signed and clamped.
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 16
`endif
`ifndef FRAC_WIDTH
`define FRAC_WIDTH 14
`endif

module ccdiv_seq #(
  parameter int unsigned TOTAL_WIDTH = `TOTAL_WIDTH,
  parameter int unsigned FRAC_WIDTH  = `FRAC_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_s_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [TOTAL_WIDTH-1:0] ar,
  input  logic signed [TOTAL_WIDTH-1:0] ai,
  input  logic signed [TOTAL_WIDTH-1:0] br,
  input  logic signed [TOTAL_WIDTH-1:0] bi,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [TOTAL_WIDTH-1:0] qr,
  output logic signed [TOTAL_WIDTH-1:0] qi,
  output logic                          div_by_zero,
  output logic                          sat
);
  localparam int unsigned W  = TOTAL_WIDTH;
  localparam int unsigned F  = FRAC_WIDTH;
  localparam int unsigned PW = 2 * W + 1;
  localparam int unsigned XW = 3 * W + F + 1;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [W-1:0] QMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] QMIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StPrep, StDiv, StFix, StDone} state_e;

  state_e              state_q;
  logic signed [W-1:0] ar_q, ai_q, br_q, bi_q;
  logic [XW-1:0]       num_r_q, num_i_q, dsh_q;
  logic [W-1:0]        quo_r_q, quo_i_q;
  logic                neg_r_q, neg_i_q, ovf_r_q, ovf_i_q, dz_q;
  logic [CW-1:0]       cnt_q;

  logic signed [PW-1:0] arx, aix, brx, bix, nr_c, ni_c, d_c;
  logic [PW-1:0]        mag_r_c, mag_i_c;
  logic [XW-1:0]        div_r_c, div_i_c, d_x_c, lim_c, sub_r_c, sub_i_c;
  logic                 ge_r_c, ge_i_c;
  logic [W:0]           fix_r_c, fix_i_c;

  // Returns {clamp, value}: the negative side can reach one step further than the positive side.
  function automatic logic [W:0] fix_comp(input logic [W-1:0] mag, input logic neg,
                                          input logic ovf);
    logic [W-1:0] val;
    logic         clamp;
    if (neg) begin
      clamp = ovf || (mag > QMIN);
      val   = clamp ? QMIN : -mag;
    end else begin
      clamp = ovf || (mag > QMAX);
      val   = clamp ? QMAX : mag;
    end
    return {clamp, val};
  endfunction

  always_comb begin
    arx     = {{(W+1){ar_q[W-1]}}, ar_q};
    aix     = {{(W+1){ai_q[W-1]}}, ai_q};
    brx     = {{(W+1){br_q[W-1]}}, br_q};
    bix     = {{(W+1){bi_q[W-1]}}, bi_q};
    nr_c    = arx * brx + aix * bix;
    ni_c    = aix * brx - arx * bix;
    d_c     = brx * brx + bix * bix;
    mag_r_c = nr_c[PW-1] ? -nr_c : nr_c;
    mag_i_c = ni_c[PW-1] ? -ni_c : ni_c;
    div_r_c = {{(XW-PW){1'b0}}, mag_r_c} << F;
    div_i_c = {{(XW-PW){1'b0}}, mag_i_c} << F;
    d_x_c   = {{(XW-PW){1'b0}}, d_c};
    lim_c   = d_x_c << W;
    ge_r_c  = num_r_q >= dsh_q;
    ge_i_c  = num_i_q >= dsh_q;
    sub_r_c = num_r_q - dsh_q;
    sub_i_c = num_i_q - dsh_q;
    fix_r_c = fix_comp(quo_r_q, neg_r_q, ovf_r_q);
    fix_i_c = fix_comp(quo_i_q, neg_i_q, ovf_i_q);
  end

  assign in_ready = (state_q == StIdle);

  always_ff @(posedge clk or negedge rst_s_n) begin
    if (!rst_s_n) begin
      state_q     <= StIdle;
      ar_q        <= '0;
      ai_q        <= '0;
      br_q        <= '0;
      bi_q        <= '0;
      num_r_q     <= '0;
      num_i_q     <= '0;
      dsh_q       <= '0;
      quo_r_q     <= '0;
      quo_i_q     <= '0;
      neg_r_q     <= 1'b0;
      neg_i_q     <= 1'b0;
      ovf_r_q     <= 1'b0;
      ovf_i_q     <= 1'b0;
      dz_q        <= 1'b0;
      cnt_q       <= '0;
      out_valid   <= 1'b0;
      qr          <= '0;
      qi          <= '0;
      sat         <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            ar_q    <= ar;
            ai_q    <= ai;
            br_q    <= br;
            bi_q    <= bi;
            state_q <= StPrep;
          end
        end
        StPrep: begin
          num_r_q <= div_r_c;
          num_i_q <= div_i_c;
          // Divisor starts aligned with the quotient MSB and walks down one bit per cycle.
          dsh_q   <= d_x_c << (W - 1);
          neg_r_q <= nr_c[PW-1];
          neg_i_q <= ni_c[PW-1];
          ovf_r_q <= div_r_c >= lim_c;
          ovf_i_q <= div_i_c >= lim_c;
          dz_q    <= (d_c == '0);
          quo_r_q <= '0;
          quo_i_q <= '0;
          cnt_q   <= '0;
          state_q <= (d_c == '0) ? StFix : StDiv;
        end
        StDiv: begin
          if (ge_r_c) num_r_q <= sub_r_c;
          if (ge_i_c) num_i_q <= sub_i_c;
          quo_r_q <= {quo_r_q[W-2:0], ge_r_c};
          quo_i_q <= {quo_i_q[W-2:0], ge_i_c};
          dsh_q   <= dsh_q >> 1;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) state_q <= StFix;
        end
        StFix: begin
          if (dz_q) begin
            qr          <= '0;
            qi          <= '0;
            sat         <= 1'b0;
            div_by_zero <= 1'b1;
          end else begin
            qr          <= fix_r_c[W-1:0];
            qi          <= fix_i_c[W-1:0];
            sat         <= fix_r_c[W] | fix_i_c[W];
            div_by_zero <= 1'b0;
          end
          out_valid <= 1'b1;
          state_q   <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ccdiv_seq.sv
// Randomised bench for ccdiv_seq: the driver queues expected quotients from an arithmetic model,
// and the monitor compares each result and its latency when the DUT presents it.
module tb_ccdiv_seq;
  localparam int W = 16;
  localparam int F = 14;
  localparam longint QMAX = (longint'(1) << (W - 1)) - 1;

  logic                clk = 1'b0;
  logic                rst_s_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] ar = '0, ai = '0, br = '0, bi = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic signed [W-1:0] qr, qi;
  logic                div_by_zero, sat;

  typedef struct {
    logic signed [W-1:0] qr;
    logic signed [W-1:0] qi;
    logic                sat;
    logic                dz;
    longint              acc;
  } exp_t;

  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  longint cyc = 0;
  bit     force_low = 1'b0;

  ccdiv_seq #(.TOTAL_WIDTH(W), .FRAC_WIDTH(F)) dut (
    .clk(clk), .rst_s_n(rst_s_n), .in_valid(in_valid), .in_ready(in_ready),
    .ar(ar), .ai(ai), .br(br), .bi(bi), .out_valid(out_valid), .out_ready(out_ready),
    .qr(qr), .qi(qi), .div_by_zero(div_by_zero), .sat(sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [W-1:0] rnd16();
    bit [31:0] r;
    r = $urandom;
    return r[W-1:0];
  endfunction

  // One component: exact floor division of |n|*2^F by d, then clamp to the signed W-bit range.
  function automatic void comp(input longint n, input longint d, output longint v, output bit c);
    longint mag, q, lim;
    bit     neg;
    neg = (n < 0);
    mag = neg ? -n : n;
    q   = (mag * (longint'(1) << F)) / d;
    lim = neg ? QMAX + 1 : QMAX;
    c   = (q > lim);
    if (c) v = neg ? -(QMAX + 1) : QMAX;
    else   v = neg ? -q : q;
  endfunction

  function automatic exp_t model(input longint a_r, a_i, b_r, b_i);
    exp_t   e;
    longint d, vr, vi;
    bit     cr, ci;
    e.qr = '0; e.qi = '0; e.sat = 1'b0; e.dz = 1'b0; e.acc = 0;
    d = b_r * b_r + b_i * b_i;
    if (d == 0) begin
      e.dz = 1'b1;
      return e;
    end
    comp(a_r * b_r + a_i * b_i, d, vr, cr);
    comp(a_i * b_r - a_r * b_i, d, vi, ci);
    e.qr  = vr[W-1:0];
    e.qi  = vi[W-1:0];
    e.sat = cr | ci;
    return e;
  endfunction

  task automatic send(input logic signed [W-1:0] a_r, a_i, b_r, b_i);
    exp_t e;
    bit   done = 1'b0;
    @(posedge clk); #1;
    ar = a_r; ai = a_i; br = b_r; bi = b_i;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e     = model(a_r, a_i, b_r, b_i);
        e.acc = cyc + 1;
        exp_q.push_back(e);
        done  = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL accept_timeout: in_ready=%0b, expected 1 within 200 cycles", in_ready);
    end
    in_valid = 1'b0;
    ar = rnd16(); ai = rnd16(); br = rnd16(); bi = rnd16();
  endtask

  task automatic wait_drain();
    int i = 0;
    while (exp_q.size() != 0 && i < 400) begin
      @(negedge clk);
      i++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d results pending, expected 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_qr"}, qr, 0);
    check({tag, "_qi"}, qi, 0);
    check({tag, "_sat"}, sat, 0);
    check({tag, "_dz"}, div_by_zero, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    check(tag, out_valid, 1);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor
  initial begin
    exp_t                e;
    bit                  pv = 1'b0, phs = 1'b0;
    logic signed [W-1:0] pqr = '0, pqi = '0;
    logic                psat = 1'b0, pdz = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_s_n) begin
        pv = 1'b0; phs = 1'b0;
      end else begin
        if (phs) begin
          check("idle_after_handshake_valid", out_valid, 0);
          check("idle_after_handshake_ready", in_ready, 1);
        end
        if (out_valid) begin
          check("in_ready_while_valid", in_ready, 0);
          if (!pv) begin
            if (exp_q.size() == 0) begin
              n_checks++; n_errors++;
              $display("FAIL unexpected_out_valid: out_valid=1, expected 0 (no operation pending)");
            end else begin
              e = exp_q[0];
              check("latency", cyc - e.acc, e.dz ? 2 : W + 2);
              check("qr", qr, e.qr);
              check("qi", qi, e.qi);
              check("sat", sat, e.sat);
              check("div_by_zero", div_by_zero, e.dz);
            end
          end else begin
            check("stall_qr", qr, pqr);
            check("stall_qi", qi, pqi);
            check("stall_sat", sat, psat);
            check("stall_dz", div_by_zero, pdz);
          end
          if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        end
        pv = out_valid; phs = out_valid && out_ready;
        pqr = qr; pqi = qi; psat = sat; pdz = div_by_zero;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic signed [W-1:0] a_r, a_i, b_r, b_i;
    int                  mode;
    #12;
    reset_checks("reset");
    @(negedge clk);
    rst_s_n = 1'b1;

    send(16384, 0, 0, 16384);
    send(8192, 8192, 8192, 8192);
    send(16384, 16384, 16384, -16384);
    send(100, -7, 0, 0);
    send(16384, -16384, 1, 0);
    send(-32768, -32768, -32768, 32767);
    wait_drain();

    for (int k = 0; k < 60; k++) begin
      mode = $urandom_range(0, 9);
      a_r = rnd16(); a_i = rnd16(); b_r = rnd16(); b_i = rnd16();
      if (mode == 0) begin
        b_r = '0; b_i = '0;
      end else if (mode <= 3) begin
        b_r = b_r >>> 9; b_i = b_i >>> 9;
      end else if (mode == 4) begin
        a_r = a_r >>> 8; a_i = a_i >>> 8;
      end
      send(a_r, a_i, b_r, b_i);
    end
    wait_drain();

    // Stalled consumer: outputs must hold and in_valid pulses must be ignored.
    force_low = 1'b1;
    send(3000, -5000, 12000, 7000);
    wait_valid("stall_reached_done");
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
      ar = rnd16(); ai = rnd16(); br = rnd16(); bi = rnd16();
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    force_low = 1'b0;
    wait_drain();

    // Reset in the middle of the division.
    send(5000, 2000, 300, -700);
    repeat (6) @(posedge clk);
    #3;
    rst_s_n = 1'b0;
    exp_q.delete();
    #1;
    reset_checks("reset_mid_div");
    @(negedge clk);
    rst_s_n = 1'b1;
    send(16384, 0, 16384, 0);
    wait_drain();

    // Reset while holding a result with the consumer stalled.
    force_low = 1'b1;
    send(-1234, 4321, 2000, -3000);
    wait_valid("stall2_reached_done");
    #2;
    rst_s_n = 1'b0;
    exp_q.delete();
    #1;
    reset_checks("reset_in_done");
    @(negedge clk);
    rst_s_n = 1'b1;
    force_low = 1'b0;
    repeat (25) @(negedge clk);
    check("no_output_after_abort", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
